// File: rtl/clk_div_pkg.sv
// Shared divisor helpers for the multi-channel clock divider.
// Helpers work on a fixed 32-bit divisor type, so DIV_W may be at most 32.
package clk_div_pkg;

  localparam int          MAX_DIV_W = 32;
  localparam int unsigned MIN_DIV   = 2;

  typedef logic [MAX_DIV_W-1:0] div_t;
  typedef logic [MAX_DIV_W:0]   half_t;

  // Divisors below 2 cannot produce a square wave, so they are raised to 2.
  function automatic div_t clamp_div(input div_t d);
    return (d < div_t'(MIN_DIV)) ? div_t'(MIN_DIV) : d;
  endfunction

  // ceil(D/2), widened by one bit so the maximum divisor cannot overflow.
  function automatic half_t half_div(input div_t d);
    return (half_t'(d) + half_t'(1)) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor and registered
// clock/tick outputs. A pending divisor is applied only at a period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 50000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_p0;
  logic [DIV_W-1:0] div_act_p0;
  logic [DIV_W-1:0] div_pend_p0;
  logic             wrap_p0;
  logic             high_p0;
  logic             bound_p0;
  logic             clk_p1;
  logic             tick_p1;

  always_comb begin
    wrap_p0  = (cnt_p0 == div_act_p0 - DIV_W'(1));
    high_p0  = (half_t'(cnt_p0) < half_div(div_t'(div_act_p0)));
    bound_p0 = !en || wrap_p0;
  end

  // p0 -> p1: outputs register the counter state of the previous cycle
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_p0     <= '0;
      div_act_p0 <= DIV_W'(DEF_DIV);
      pending    <= 1'b0;
      clk_p1     <= 1'b0;
      tick_p1    <= 1'b0;
    end else begin
      clk_p1  <= en && high_p0;
      tick_p1 <= en && wrap_p0;
      if (bound_p0) begin
        cnt_p0 <= '0;
        if (pending) begin
          div_act_p0 <= div_pend_p0;
          pending    <= 1'b0;
        end
      end else begin
        cnt_p0 <= cnt_p0 + DIV_W'(1);
      end
      // A load is only offered while nothing is pending, so it never races the apply above.
      if (load) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (load) begin
      div_pend_p0 <= DIV_W'(clamp_div(div_t'(load_div)));
    end
  end

  assign clk_out = clk_p1;
  assign tick    = tick_p1;

endmodule

// File: rtl/clk_div_multi.sv
// CH independent programmable clock dividers sharing one config port.
// Out-of-range channel indices are acknowledged and discarded.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  CH      = 4,
  parameter int  DIV_W   = 16,
  parameter int  DEF_DIV = 50000,
  localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [CH-1:0]    cfg_pending,
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    tick
);

  logic [CH-1:0] load;

  always_comb begin
    cfg_ready = 1'b1;
    load      = '0;
    for (int i = 0; i < CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !cfg_pending[i];
      end
    end
    for (int i = 0; i < CH; i++) begin
      load[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en[g]),
      .load     (load[g]),
      .load_div (cfg_div),
      .pending  (cfg_pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic, all checked
// against a per-channel period model (a CH=4 and a CH=5 instance are exercised).
module tb_clk_div_multi;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_pending;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  logic [4:0]  en5;
  logic        cfg_valid5;
  logic        cfg_ready5;
  logic [2:0]  cfg_ch5;
  logic [15:0] cfg_div5;
  logic [4:0]  cfg_pending5;
  logic [4:0]  clk_out5;
  logic [4:0]  tick5;

  int checks = 0;
  int errors = 0;

  // Model: position within the current period, active/stored divisors, outputs.
  int pos[2][5];
  int act[2][5];
  int pv[2][5];
  bit pd[2][5];
  bit mc[2][5];
  bit mt[2][5];

  always #5 clk_in = ~clk_in;

  clk_div_multi #(.CH(4), .DIV_W(16), .DEF_DIV(4)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_pending (cfg_pending),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  clk_div_multi #(.CH(5), .DIV_W(16), .DEF_DIV(4)) dut5 (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en5),
    .cfg_valid   (cfg_valid5),
    .cfg_ready   (cfg_ready5),
    .cfg_ch      (cfg_ch5),
    .cfg_div     (cfg_div5),
    .cfg_pending (cfg_pending5),
    .clk_out     (clk_out5),
    .tick        (tick5)
  );

  function automatic int nch(input int m);
    return (m == 0) ? 4 : 5;
  endfunction

  function automatic bit model_ready(input int m);
    int c;
    c = (m == 0) ? int'(cfg_ch) : int'(cfg_ch5);
    if (c >= nch(m)) return 1'b1;
    return !pd[m][c];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      bit acc;
      int c;
      int d;
      bit e;
      bit last;
      c   = (m == 0) ? int'(cfg_ch) : int'(cfg_ch5);
      d   = (m == 0) ? int'(cfg_div) : int'(cfg_div5);
      acc = ((m == 0) ? cfg_valid : cfg_valid5) && model_ready(m);
      for (int i = 0; i < nch(m); i++) begin
        if (rst) begin
          pos[m][i] = 0;
          act[m][i] = 4;
          pd[m][i]  = 1'b0;
          mc[m][i]  = 1'b0;
          mt[m][i]  = 1'b0;
        end else begin
          e    = (m == 0) ? en[i] : en5[i];
          last = (pos[m][i] == act[m][i] - 1);
          mc[m][i] = e && (pos[m][i] < (act[m][i] + 1) / 2);
          mt[m][i] = e && last;
          if (!e || last) begin
            pos[m][i] = 0;
            if (pd[m][i]) begin
              act[m][i] = pv[m][i];
              pd[m][i]  = 1'b0;
            end
          end else begin
            pos[m][i] = pos[m][i] + 1;
          end
          if (acc && c == i) begin
            pv[m][i] = (d < 2) ? 2 : d;
            pd[m][i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < nch(m); i++) begin
        check($sformatf("m%0d clk_out[%0d]", m, i), (m == 0) ? clk_out[i] : clk_out5[i], mc[m][i]);
        check($sformatf("m%0d tick[%0d]", m, i), (m == 0) ? tick[i] : tick5[i], mt[m][i]);
        check($sformatf("m%0d pending[%0d]", m, i), (m == 0) ? cfg_pending[i] : cfg_pending5[i], pd[m][i]);
      end
      check($sformatf("m%0d cfg_ready", m), (m == 0) ? cfg_ready : cfg_ready5, model_ready(m));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic cfg_write(input int c, input int d);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(c);
    cfg_div   = 16'(d);
    #1;
    check("wr ready", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input int c, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[c] && n < bound);
    check("wait tick", tick[c], 1);
  endtask

  task automatic wait_pending(input int c, input int bound);
    int n;
    n = 0;
    while (cfg_pending[c] && n < bound) begin
      step();
      n++;
    end
    check("pending clear", cfg_pending[c], 0);
  endtask

  function automatic logic [15:0] rand_div();
    int unsigned s;
    s = $urandom_range(7);
    if (s == 0) return 16'd0;
    if (s == 1) return 16'd1;
    return 16'($urandom_range(12, 2));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    bit [0:12] clk_pat;
    bit [0:12] tick_pat;
    bit [0:9]  odd_clk;
    bit [0:9]  odd_tick;
    clk_pat  = 13'b0110011001100;
    tick_pat = 13'b0000100010001;
    odd_clk  = 10'b1110011100;
    odd_tick = 10'b0000100001;

    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    en5 = '0; cfg_valid5 = 1'b0; cfg_ch5 = '0; cfg_div5 = '0;
    step();
    step();

    // Reset defaults with D=4
    rst = 1'b0; en = 4'hF; en5 = 5'h1F;
    check("rst clk0 k0", clk_out[0], clk_pat[0]);
    check("rst all out", {clk_out, tick, cfg_pending}, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("rst clk0 k%0d", k), clk_out[0], clk_pat[k]);
      check($sformatf("rst tick0 k%0d", k), tick[0], tick_pat[k]);
    end

    // Odd divisor on ch1
    cfg_write(1, 5);
    wait_pending(1, 10);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("odd clk1 k%0d", k), clk_out[1], odd_clk[k]);
      check($sformatf("odd tick1 k%0d", k), tick[1], odd_tick[k]);
    end

    // Boundary update on ch2: D=10, rewrite to 3 at cnt=4
    cfg_write(2, 10);
    wait_pending(2, 20);
    for (int k = 0; k < 4; k++) step();
    cfg_write(2, 3);
    cnt = 5;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd7;
    while (!tick[2] && cnt < 20) begin
      check("bnd pending2", cfg_pending[2], 1);
      check("bnd ready2", cfg_ready, 0);
      step();
      cnt++;
    end
    cfg_valid = 1'b0;
    check("bnd old period", cnt, 10);
    wait_tick(2, 10, n);
    check("bnd new period", n, 3);

    // Clamp of 0 and 1
    cfg_write(1, 0);
    wait_pending(1, 10);
    wait_tick(1, 10, n);
    check("clamp0 period", n, 2);
    cfg_write(1, 1);
    wait_pending(1, 10);
    wait_tick(1, 10, n);
    check("clamp1 period", n, 2);

    // Out-of-range channel on the CH=5 instance
    cfg_valid5 = 1'b1; cfg_ch5 = 3'd7; cfg_div5 = 16'd9;
    #1;
    check("oor ready", cfg_ready5, 1);
    step();
    cfg_valid5 = 1'b0;
    check("oor pending", cfg_pending5, 0);
    for (int k = 0; k < 8; k++) step();

    // Disable with a pending write on ch3
    cfg_write(3, 6);
    check("dis pend before", cfg_pending[3], 1);
    en[3] = 1'b0;
    step();
    check("dis clk3", clk_out[3], 0);
    check("dis tick3", tick[3], 0);
    check("dis pend3", cfg_pending[3], 0);
    en[3] = 1'b1;
    wait_tick(3, 20, n);
    check("reen period", n, 6);

    // Random traffic
    for (int r = 0; r < 400; r++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(15) == 0) en[i] = ~en[i];
      for (int i = 0; i < 5; i++) if ($urandom_range(15) == 0) en5[i] = ~en5[i];
      cfg_valid  = ($urandom_range(3) == 0);
      cfg_ch     = 2'($urandom_range(3));
      cfg_div    = rand_div();
      cfg_valid5 = ($urandom_range(3) == 0);
      cfg_ch5    = 3'($urandom_range(7));
      cfg_div5   = rand_div();
      step();
    end

    // Reset mid-operation with writes pending on every channel
    cfg_valid = 1'b0; cfg_valid5 = 1'b0; en = '0; en5 = 5'h1F;
    step();
    step();
    for (int c = 0; c < 4; c++) cfg_write(c, 60000);
    step();
    en = 4'hF;
    for (int c = 0; c < 4; c++) cfg_write(c, 5);
    check("mid all pending", cfg_pending, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid pending", cfg_pending, 0);
    check("mid clk", clk_out, 0);
    check("mid tick", tick, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("mid clk k%0d", k), clk_out, {4{clk_pat[k]}});
      check($sformatf("mid tick k%0d", k), tick, {4{tick_pat[k]}});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
